// File: rtl/dbus_pkg.sv
// Shared types for the data-bus arbiter: FSM states, bus owner, decode target
// and the tag carried alongside each outstanding read.
package dbus_pkg;

    typedef enum logic [1:0] {
        CORE  = 2'd0,
        DRAIN = 2'd1,
        EXT   = 2'd2,
        RET   = 2'd3
    } state_e;

    typedef enum logic {
        OWN_CORE = 1'b0,
        OWN_EXT  = 1'b1
    } owner_e;

    typedef enum logic {
        TGT_RAM  = 1'b0,
        TGT_UART = 1'b1
    } target_e;

    // Bit positions inside the 4-bit {byte,half,word,unsigned} mode field
    localparam int MODE_BYTE     = 3;
    localparam int MODE_HALF     = 2;
    localparam int MODE_WORD     = 1;
    localparam int MODE_UNSIGNED = 0;

    typedef struct packed {
        logic    vld;
        owner_e  owner;
        target_e target;
    } rd_tag_t;

    function automatic logic mode_size_ok(input logic [3:0] mode);
        logic [3:0] size;
        size                = mode;
        size[MODE_UNSIGNED] = 1'b0;
        return (size == 4'(1 << MODE_BYTE)) ||
               (size == 4'(1 << MODE_HALF)) ||
               (size == 4'(1 << MODE_WORD));
    endfunction

endpackage

// File: rtl/dbus_rd_pipe.sv
// Shift pipe that tracks outstanding reads so returning data can be routed to
// the requesting owner from the correct target, RD_LAT cycles after issue.
module dbus_rd_pipe
    import dbus_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic    clk_i,
    input  logic    rst_i,
    input  rd_tag_t tag_i,
    output rd_tag_t tag_o,
    output logic    empty_o
);

    rd_tag_t stage_q [RD_LAT];
    rd_tag_t stage_d [RD_LAT];

    always_comb begin
        stage_d[0] = tag_i;
        for (int i = 1; i < RD_LAT; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < RD_LAT; i++) begin
            if (rst_i) begin
                stage_q[i] <= '0;
            end else begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    always_comb begin
        empty_o = 1'b1;
        for (int i = 0; i < RD_LAT; i++) begin
            if (stage_q[i].vld) begin
                empty_o = 1'b0;
            end
        end
    end

    assign tag_o = stage_q[RD_LAT-1];

endmodule

// File: rtl/dbus_arbiter.sv
// Data-bus arbiter between the core load/store port and an external master,
// with RAM/UART decode and read-data return routed to whichever owner issued.
//
// state | meaning
// CORE  | core owns the bus and runs; ext request starts a handover
// DRAIN | core stalled, waiting for its outstanding reads to return
// EXT   | ext master owns the bus, one grant per requested cycle
// RET   | core stalled until ext reads return; next CORE cycle is the core slot
module dbus_arbiter
    import dbus_pkg::*;
#(
    parameter logic [31:0] UART_BASE = 32'h8000_0000,
    parameter logic [31:0] UART_MASK = 32'hFFFF_FF00,
    parameter int          RD_LAT    = 1,
    parameter int          EXT_MAX   = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wdata_i,
    input  logic        core_wr_en_i,
    input  logic        core_rd_en_i,
    input  logic [3:0]  core_mode_i,
    output logic [31:0] core_rdata_o,
    output logic        core_rdata_vld_o,
    output logic        core_clk_en_o,
    input  logic        ext_req_i,
    input  logic        ext_we_i,
    input  logic [31:0] ext_addr_i,
    input  logic [31:0] ext_wdata_i,
    input  logic [3:0]  ext_mode_i,
    output logic        ext_gnt_o,
    output logic [31:0] ext_rdata_o,
    output logic        ext_rdata_vld_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_mode_o,
    output logic        ram_wr_en_o,
    output logic        ram_rd_en_o,
    input  logic [31:0] ram_rdata_i,
    output logic        uart_wr_en_o,
    output logic        uart_rd_en_o,
    input  logic [31:0] uart_rdata_i
);

    state_e     state_q, state_d;
    logic [7:0] ext_cnt_q, ext_cnt_d;
    owner_e     owner;
    logic       acc_wr, acc_rd;
    logic       core_acc;
    logic       uart_hit;
    logic       pipe_empty;
    rd_tag_t    tag_in, tag_out;
    logic [31:0] rd_data;

    assign core_acc = core_wr_en_i | core_rd_en_i;

    always_comb begin
        state_d       = state_q;
        ext_cnt_d     = ext_cnt_q;
        core_clk_en_o = 1'b0;
        ext_gnt_o     = 1'b0;
        owner         = OWN_CORE;
        acc_wr        = 1'b0;
        acc_rd        = 1'b0;
        case (state_q)
            CORE: begin
                core_clk_en_o = 1'b1;
                acc_wr        = core_wr_en_i;
                acc_rd        = core_rd_en_i & ~core_wr_en_i;
                if (ext_req_i) begin
                    state_d = (!core_acc && pipe_empty) ? EXT : DRAIN;
                end
            end
            DRAIN: begin
                if (pipe_empty) begin
                    state_d = EXT;
                end
            end
            EXT: begin
                owner     = OWN_EXT;
                ext_gnt_o = ext_req_i;
                acc_wr    = ext_req_i & ext_we_i;
                acc_rd    = ext_req_i & ~ext_we_i;
                // The grant that reaches EXT_MAX is still taken before leaving
                if (!ext_req_i || ext_cnt_q == 8'(EXT_MAX - 1)) begin
                    state_d   = RET;
                    ext_cnt_d = '0;
                end else begin
                    ext_cnt_d = ext_cnt_q + 8'd1;
                end
            end
            RET: begin
                if (pipe_empty) begin
                    state_d = CORE;
                end
            end
            default: state_d = CORE;
        endcase
        if (rst_i) begin
            ext_gnt_o = 1'b0;
            acc_wr    = 1'b0;
            acc_rd    = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= CORE;
            ext_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            ext_cnt_q <= ext_cnt_d;
        end
    end

    assign mem_addr_o  = (owner == OWN_EXT) ? ext_addr_i  : core_addr_i;
    assign mem_wdata_o = (owner == OWN_EXT) ? ext_wdata_i : core_wdata_i;
    assign mem_mode_o  = (owner == OWN_EXT) ? ext_mode_i  : core_mode_i;

    assign uart_hit = ((mem_addr_o & UART_MASK) == (UART_BASE & UART_MASK));

    assign ram_wr_en_o  = acc_wr & ~uart_hit;
    assign ram_rd_en_o  = acc_rd & ~uart_hit;
    assign uart_wr_en_o = acc_wr &  uart_hit;
    assign uart_rd_en_o = acc_rd &  uart_hit;

    assign tag_in.vld    = acc_rd;
    assign tag_in.owner  = owner;
    assign tag_in.target = uart_hit ? TGT_UART : TGT_RAM;

    dbus_rd_pipe #(
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .tag_i   (tag_in),
        .tag_o   (tag_out),
        .empty_o (pipe_empty)
    );

    assign rd_data          = (tag_out.target == TGT_UART) ? uart_rdata_i : ram_rdata_i;
    assign core_rdata_vld_o = tag_out.vld && (tag_out.owner == OWN_CORE);
    assign ext_rdata_vld_o  = tag_out.vld && (tag_out.owner == OWN_EXT);
    assign core_rdata_o     = core_rdata_vld_o ? rd_data : '0;
    assign ext_rdata_o      = ext_rdata_vld_o  ? rd_data : '0;

    // A core load and store in the same cycle is illegal; the store wins
    always_ff @(posedge clk_i) begin
        if (!rst_i && core_clk_en_o && core_acc) begin
            assert (!(core_wr_en_i && core_rd_en_i));
            assert (mode_size_ok(core_mode_i));
        end
    end

endmodule

// File: tb/tb_dbus_arbiter.sv
// Directed bench for dbus_arbiter: scoreboard of expected read returns plus
// per-step checks of strobes, grants and the core clock enable.
module tb_dbus_arbiter;

    logic        clk, rst;
    logic [31:0] core_addr, core_wdata;
    logic        core_wr_en, core_rd_en;
    logic [3:0]  core_mode;
    logic [31:0] core_rdata;
    logic        core_rdata_vld, core_clk_en;
    logic        ext_req, ext_we;
    logic [31:0] ext_addr, ext_wdata;
    logic [3:0]  ext_mode;
    logic        ext_gnt;
    logic [31:0] ext_rdata;
    logic        ext_rdata_vld;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_mode;
    logic        ram_wr_en, ram_rd_en, uart_wr_en, uart_rd_en;
    logic [31:0] ram_rdata, uart_rdata;

    typedef struct {
        logic        is_ext;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    dbus_arbiter #(
        .RD_LAT  (2),
        .EXT_MAX (4)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .core_addr_i      (core_addr),
        .core_wdata_i     (core_wdata),
        .core_wr_en_i     (core_wr_en),
        .core_rd_en_i     (core_rd_en),
        .core_mode_i      (core_mode),
        .core_rdata_o     (core_rdata),
        .core_rdata_vld_o (core_rdata_vld),
        .core_clk_en_o    (core_clk_en),
        .ext_req_i        (ext_req),
        .ext_we_i         (ext_we),
        .ext_addr_i       (ext_addr),
        .ext_wdata_i      (ext_wdata),
        .ext_mode_i       (ext_mode),
        .ext_gnt_o        (ext_gnt),
        .ext_rdata_o      (ext_rdata),
        .ext_rdata_vld_o  (ext_rdata_vld),
        .mem_addr_o       (mem_addr),
        .mem_wdata_o      (mem_wdata),
        .mem_mode_o       (mem_mode),
        .ram_wr_en_o      (ram_wr_en),
        .ram_rd_en_o      (ram_rd_en),
        .ram_rdata_i      (ram_rdata),
        .uart_wr_en_o     (uart_wr_en),
        .uart_rd_en_o     (uart_rd_en),
        .uart_rdata_i     (uart_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        tests++;
        assert (obs === want) else begin
            fails++;
            $error("FAIL %s: got %h want %h", tag, obs, want);
        end
    endtask

    task automatic wait_core(input string tag);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            smp();
            if (core_clk_en === 1'b1) ok = 1'b1;
            else cyc();
        end
        chk(tag, 32'(ok), 32'd1);
        cyc();
    endtask

    // Read-return monitor: every valid strobe must match the oldest expectation
    always @(negedge clk) begin
        exp_t e;
        if (core_rdata_vld === 1'b1 || ext_rdata_vld === 1'b1) begin
            tests++;
            assert (sb.size() > 0) else begin
                fails++;
                $error("FAIL sb_unexpected: got vld core=%0b ext=%0b want no return", core_rdata_vld, ext_rdata_vld);
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                tests++;
                assert ({ext_rdata_vld, core_rdata_vld} === (e.is_ext ? 2'b10 : 2'b01)) else begin
                    fails++;
                    $error("FAIL sb_owner: got ext/core vld %b%b want ext=%0b", ext_rdata_vld, core_rdata_vld, e.is_ext);
                end
                tests++;
                assert ((ext_rdata_vld ? ext_rdata : core_rdata) === e.data) else begin
                    fails++;
                    $error("FAIL sb_data: got %h want %h", (ext_rdata_vld ? ext_rdata : core_rdata), e.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen, got;
        int   gnt_log [10];
        int   en_log  [10];
        int   run1, run2, slot, phase, overlap, vld_cnt;

        rst = 1'b1;
        core_addr = '0; core_wdata = '0; core_wr_en = 1'b0; core_rd_en = 1'b0;
        core_mode = 4'b0010;
        ext_req = 1'b0; ext_we = 1'b0; ext_addr = '0; ext_wdata = '0; ext_mode = 4'b0010;
        ram_rdata = '0; uart_rdata = '0;

        cyc(); cyc(); smp();
        chk("rst_clk_en",   32'(core_clk_en), 32'd1);
        chk("rst_gnt",      32'(ext_gnt), 32'd0);
        chk("rst_strobes",  32'({ram_wr_en, ram_rd_en, uart_wr_en, uart_rd_en}), 32'd0);
        chk("rst_vld",      32'({core_rdata_vld, ext_rdata_vld}), 32'd0);
        chk("rst_rdata",    core_rdata | ext_rdata, 32'd0);
        cyc();
        rst = 1'b0;

        // Core read from RAM
        core_rd_en = 1'b1; core_addr = 32'h0000_0010; ram_rdata = 32'hDEAD_BEEF;
        sb.push_back('{1'b0, 32'hDEAD_BEEF});
        smp();
        chk("crd_ram_rd", 32'(ram_rd_en), 32'd1);
        chk("crd_uart",   32'({uart_rd_en, uart_wr_en}), 32'd0);
        chk("crd_addr",   mem_addr, 32'h0000_0010);
        cyc();
        core_rd_en = 1'b0;
        smp();
        chk("crd_lat_early", 32'(core_rdata_vld), 32'd0);
        cyc(); smp();
        chk("crd_lat_vld",   32'(core_rdata_vld), 32'd1);
        chk("crd_uart_idle", 32'({uart_rd_en, uart_wr_en}), 32'd0);
        cyc();

        // Core read from UART window
        core_rd_en = 1'b1; core_addr = 32'h8000_0010; uart_rdata = 32'h0000_00A5; ram_rdata = 32'h1111_1111;
        sb.push_back('{1'b0, 32'h0000_00A5});
        smp();
        chk("urd_uart_rd", 32'(uart_rd_en), 32'd1);
        chk("urd_ram_rd",  32'(ram_rd_en), 32'd0);
        cyc();
        core_rd_en = 1'b0;
        cyc(); cyc();

        // Core write to UART
        core_wr_en = 1'b1; core_addr = 32'h8000_0004; core_wdata = 32'h0000_0041;
        smp();
        chk("uwr_uart_wr", 32'(uart_wr_en), 32'd1);
        chk("uwr_ram_wr",  32'(ram_wr_en), 32'd0);
        chk("uwr_wdata",   mem_wdata, 32'h0000_0041);
        cyc();
        core_wr_en = 1'b0;

        // Handover: core read and ext request together
        core_rd_en = 1'b1; core_addr = 32'h0000_0014; ram_rdata = 32'h1234_5678;
        ext_req = 1'b1; ext_we = 1'b1; ext_addr = 32'h0000_0100; ext_wdata = 32'h0000_0055;
        sb.push_back('{1'b0, 32'h1234_5678});
        smp();
        chk("ho_core_rd",  32'(ram_rd_en), 32'd1);
        chk("ho_no_gnt",   32'(ext_gnt), 32'd0);
        cyc();
        core_rd_en = 1'b0;
        smp();
        chk("ho_stall",    32'(core_clk_en), 32'd0);
        chk("ho_gnt_wait", 32'(ext_gnt), 32'd0);
        seen = 1'b0; got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            cyc(); smp();
            if (ext_gnt === 1'b1) begin
                got = 1'b1;
                chk("ho_order",    32'(seen), 32'd1);
                chk("ho_ext_addr", mem_addr, 32'h0000_0100);
                chk("ho_ext_wr",   32'(ram_wr_en), 32'd1);
                chk("ho_ext_data", mem_wdata, 32'h0000_0055);
                chk("ho_ext_stall", 32'(core_clk_en), 32'd0);
            end
            if (core_rdata_vld === 1'b1) seen = 1'b1;
        end
        chk("ho_gnt_seen", 32'(got), 32'd1);
        cyc();
        ext_req = 1'b0;
        wait_core("ho_return");

        // Ext write burst limited to four grants
        ext_req = 1'b1; ext_we = 1'b1; ext_addr = 32'h0000_0200;
        for (int i = 0; i < 10; i++) begin
            smp();
            gnt_log[i] = int'(ext_gnt);
            en_log[i]  = int'(core_clk_en);
            cyc();
        end
        ext_req = 1'b0;
        run1 = 0; run2 = 0; slot = 0; phase = 0; overlap = 0;
        for (int i = 0; i < 10; i++) begin
            if (gnt_log[i] != 0 && en_log[i] != 0) overlap++;
            case (phase)
                0: if (gnt_log[i] != 0) begin run1++; phase = 1; end
                1: if (gnt_log[i] != 0) run1++; else begin phase = 2; slot += en_log[i]; end
                2: if (gnt_log[i] != 0) begin run2++; phase = 3; end else slot += en_log[i];
                default: if (gnt_log[i] != 0) run2++;
            endcase
        end
        chk("burst_run1",    32'(run1), 32'd4);
        chk("burst_slot",    32'(slot), 32'd1);
        chk("burst_regrant", 32'(run2 > 0), 32'd1);
        chk("burst_overlap", 32'(overlap), 32'd0);
        wait_core("burst_return");

        // Ext read: core held in RET until the data comes back
        ext_req = 1'b1; ext_we = 1'b0; ext_addr = 32'h0000_0020; ram_rdata = 32'hCAFE_0001;
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            smp();
            if (ext_gnt === 1'b1) begin
                got = 1'b1;
                sb.push_back('{1'b1, 32'hCAFE_0001});
                chk("erd_ram_rd", 32'(ram_rd_en), 32'd1);
                chk("erd_addr",   mem_addr, 32'h0000_0020);
            end
            cyc();
        end
        chk("erd_gnt_seen", 32'(got), 32'd1);
        ext_req = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            smp();
            chk("erd_ret_hold", 32'(core_clk_en), 32'd0);
            if (ext_rdata_vld === 1'b1) seen = 1'b1;
            cyc();
        end
        chk("erd_vld_seen", 32'(seen), 32'd1);
        wait_core("erd_return");

        // Reset while a read is in flight
        core_rd_en = 1'b1; core_addr = 32'h0000_0010; ram_rdata = 32'hBAD0_BAD0;
        smp();
        chk("rmr_issue", 32'(ram_rd_en), 32'd1);
        cyc();
        core_rd_en = 1'b0;
        rst = 1'b1;
        sb.delete();
        cyc();
        rst = 1'b0;
        vld_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            smp();
            if (core_rdata_vld === 1'b1 || ext_rdata_vld === 1'b1) vld_cnt++;
            chk("rmr_clk_en", 32'(core_clk_en), 32'd1);
            cyc();
        end
        chk("rmr_no_vld", 32'(vld_cnt), 32'd0);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
